// File: rtl/if_pc_unit.sv
// Instruction-fetch PC generator: holds the fetch PC, selects the next PC,
// remembers redirects that arrive during a stall and squashes wrong-path fetches.
module if_pc_unit #(
    parameter logic [31:0] RESET_PC   = 32'h00000000,
    parameter logic [31:0] EXC_VECTOR = 32'h00000004
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ena,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc_in,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jump_req,
    input  logic [31:0] jump_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_pc_out,
    output logic [31:0] if_instr_out,
    output logic        pc_addr_err,
    output logic        redirect_pending
);

    typedef enum logic {RUN, PEND} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc_out, pc_nxt;
    logic [31:0] pend_pc, pend_pc_nxt;
    logic [1:0]  pend_pri, pend_pri_nxt;

    logic        redir;
    logic [31:0] sel_target;
    logic [1:0]  sel_pri;

    // Fixed-priority redirect select; larger sel_pri means higher priority.
    always_comb begin
        redir      = 1'b1;
        sel_target = pc_out + 32'd4;
        sel_pri    = 2'd0;
        if (exc_req) begin
            sel_target = EXC_VECTOR;
            sel_pri    = 2'd3;
        end else if (eret_req) begin
            sel_target = epc_in;
            sel_pri    = 2'd2;
        end else if (br_taken) begin
            sel_target = br_target;
            sel_pri    = 2'd1;
        end else if (jump_req) begin
            sel_target = jump_target;
            sel_pri    = 2'd0;
        end else begin
            redir = 1'b0;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc_out;
        pend_pc_nxt  = pend_pc;
        pend_pri_nxt = pend_pri;
        case (state)
            RUN: begin
                if (ena) begin
                    pc_nxt = sel_target;
                end else if (redir) begin
                    pend_pc_nxt  = sel_target;
                    pend_pri_nxt = sel_pri;
                    state_nxt    = PEND;
                end
            end
            PEND: begin
                // Only a strictly higher-priority request may displace the held one.
                if (ena) begin
                    state_nxt = RUN;
                    if (redir && (sel_pri > pend_pri))
                        pc_nxt = sel_target;
                    else
                        pc_nxt = pend_pc;
                end else if (redir && (sel_pri > pend_pri)) begin
                    pend_pc_nxt  = sel_target;
                    pend_pri_nxt = sel_pri;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= RUN;
            pc_out   <= RESET_PC;
            pend_pc  <= 32'h00000000;
            pend_pri <= 2'd0;
        end else begin
            state    <= state_nxt;
            pc_out   <= pc_nxt;
            pend_pc  <= pend_pc_nxt;
            pend_pri <= pend_pri_nxt;
        end
    end

    assign imem_addr        = pc_out;
    assign if_pc_out        = pc_out;
    assign pc_addr_err      = |pc_out[1:0];
    assign redirect_pending = (state == PEND);
    assign if_instr_out     = (redir || (state == PEND)) ? 32'h00000000 : imem_rdata;

endmodule

// File: tb/tb_if_pc_unit.sv
// Directed self-checking bench for if_pc_unit; IMEM returns ~address so fetched
// instructions are predictable from the expected PC.
module tb_if_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        ena;
    logic        exc_req, eret_req, br_taken, jump_req;
    logic [31:0] epc_in, br_target, jump_target;
    logic [31:0] imem_addr, imem_rdata, if_pc_out, if_instr_out;
    logic        pc_addr_err, redirect_pending;

    int total = 0;
    int bad   = 0;

    if_pc_unit #(.RESET_PC(32'h00000000), .EXC_VECTOR(32'h00000004)) dut (
        .clk(clk), .reset(reset), .ena(ena),
        .exc_req(exc_req), .eret_req(eret_req), .epc_in(epc_in),
        .br_taken(br_taken), .br_target(br_target),
        .jump_req(jump_req), .jump_target(jump_target),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .if_pc_out(if_pc_out), .if_instr_out(if_instr_out),
        .pc_addr_err(pc_addr_err), .redirect_pending(redirect_pending)
    );

    always #5 clk = ~clk;

    assign imem_rdata = ~imem_addr;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic clearReqs();
        exc_req  = 1'b0;
        eret_req = 1'b0;
        br_taken = 1'b0;
        jump_req = 1'b0;
        #1;
    endtask

    task automatic checkFetch(input string tag, input logic [31:0] pc);
        checkOutput({tag, "_addr"}, imem_addr, pc);
        checkOutput({tag, "_pc"}, if_pc_out, pc);
        checkOutput({tag, "_instr"}, if_instr_out, ~pc);
        checkOutput({tag, "_pend"}, {31'b0, redirect_pending}, 32'd0);
    endtask

    initial begin
        reset = 1'b0; ena = 1'b1;
        epc_in = 32'h0; br_target = 32'h0; jump_target = 32'h0;
        clearReqs();
        @(negedge clk); #1;
        checkFetch("reset", 32'h0);
        checkOutput("reset_aerr", {31'b0, pc_addr_err}, 32'd0);

        // Sequential fetch after reset release
        reset = 1'b1; #1;
        checkFetch("seq0", 32'h0);
        step(); checkFetch("seq1", 32'h4);
        step(); checkFetch("seq2", 32'h8);
        step(); checkFetch("seq3", 32'hC);
        step(); checkFetch("seq4", 32'h10);

        // Branch with ena=1 squashes the current slot
        br_taken = 1'b1; br_target = 32'h40; #1;
        checkOutput("br_squash", if_instr_out, 32'h0);
        step(); clearReqs();
        checkFetch("br_tgt", 32'h40);
        step(); checkFetch("br_seq", 32'h44);

        // Jump during stall is held until ena returns
        ena = 1'b0; jump_req = 1'b1; jump_target = 32'h80; #1;
        checkOutput("stall_squash", if_instr_out, 32'h0);
        step(); clearReqs();
        for (int i = 0; i < 3; i++) begin
            checkOutput("stall_pc", imem_addr, 32'h44);
            checkOutput("stall_pend", {31'b0, redirect_pending}, 32'd1);
            checkOutput("stall_instr", if_instr_out, 32'h0);
            if (i < 2) step();
        end
        ena = 1'b1; #1;
        step(); checkFetch("held_jump", 32'h80);

        // Simultaneous requests: exception wins
        exc_req = 1'b1; br_taken = 1'b1; br_target = 32'h40;
        jump_req = 1'b1; jump_target = 32'h200; #1;
        step(); clearReqs();
        checkFetch("prio_exc", 32'h4);
        step(); checkFetch("prio_seq", 32'h8);

        // Held branch overwritten by exception; later jump dropped
        ena = 1'b0; br_taken = 1'b1; br_target = 32'h40; #1;
        step(); clearReqs();
        checkOutput("ov_pend", {31'b0, redirect_pending}, 32'd1);
        exc_req = 1'b1; #1;
        step(); clearReqs();
        jump_req = 1'b1; jump_target = 32'h300; #1;
        step(); clearReqs();
        checkOutput("ov_hold", imem_addr, 32'h8);
        ena = 1'b1; #1;
        step(); checkFetch("ov_exc", 32'h4);

        // Release cycle: strictly higher new request beats the held one
        ena = 1'b0; jump_req = 1'b1; jump_target = 32'h600; #1;
        step(); clearReqs();
        ena = 1'b1; br_taken = 1'b1; br_target = 32'h700; #1;
        step(); clearReqs();
        checkFetch("rel_win", 32'h700);

        // Modulo wrap, then eret to a misaligned address
        jump_req = 1'b1; jump_target = 32'hFFFFFFFC; #1;
        step(); clearReqs();
        checkFetch("wrap_pre", 32'hFFFFFFFC);
        step(); checkFetch("wrap", 32'h0);
        eret_req = 1'b1; epc_in = 32'h102; #1;
        step(); clearReqs();
        checkFetch("eret", 32'h102);
        checkOutput("eret_aerr", {31'b0, pc_addr_err}, 32'd1);

        // Reset while pending discards the held redirect
        ena = 1'b0; br_taken = 1'b1; br_target = 32'h500; #1;
        step(); clearReqs();
        checkOutput("rst_pend_pre", {31'b0, redirect_pending}, 32'd1);
        #2 reset = 1'b0; #1;
        checkOutput("rst_async_pc", imem_addr, 32'h0);
        checkOutput("rst_async_pend", {31'b0, redirect_pending}, 32'd0);
        @(negedge clk);
        ena = 1'b1; reset = 1'b1; #1;
        checkFetch("rst_rel0", 32'h0);
        step(); checkFetch("rst_rel1", 32'h4);
        step(); checkFetch("rst_rel2", 32'h8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_pc_unit.md
Name: if_pc_unit

Overview:
- Instruction-fetch PC generator; sits directly upstream of the IF/ID pipeline register.
- Holds the fetch PC, drives the IMEM address, and computes the next PC.
- Sources for the next PC: sequential, branch, jump, exception entry, eret return.
- Forwards the fetched PC and instruction to IF/ID. Wrong-path instructions are squashed to NOP (32'h00000000). Redirects that arrive while the pipeline is stalled are held until the stall releases.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- EXC_VECTOR, 32'h00000004, exception entry address.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- ena  input  1  PipelineController fetch/IF-ID enable; 0 = stall.
- exc_req  input  1  exception entry pulse (from CP0/EX).
- eret_req  input  1  eret pulse.
- epc_in  input  32  eret return address, valid with eret_req.
- br_taken  input  1  branch-taken pulse.
- br_target  input  32  branch target, valid with br_taken.
- jump_req  input  1  jump/jal/jr pulse.
- jump_target  input  32  jump target, valid with jump_req.
- imem_addr  output  32  IMEM read address; equals pc_out.
- imem_rdata  input  32  IMEM spo, combinational read of imem_addr.
- if_pc_out  output  32  PC to IF/ID if_pc_in.
- if_instr_out  output  32  instruction to IF/ID if_instr_in; 0 when squashed.
- pc_addr_err  output  1  pc_out[1:0] != 0.
- redirect_pending  output  1  a held redirect is waiting for ena.

Behaviour:
- Reset (reset low, asynchronous): pc_out = RESET_PC; state = RUN; pend_pc = 0.
  - Resulting outputs: if_pc_out = RESET_PC, redirect_pending = 0, if_instr_out = imem_rdata.
  - Reset mid-stall discards any held redirect.
- Outputs:
  - if_pc_out = imem_addr = pc_out.
  - pc_addr_err = |pc_out[1:0], combinational; no alignment correction; the PC is fetched as-is.
- Redirect selection, priority fixed, combinational each cycle:
  - exc_req -> EXC_VECTOR
  - eret_req -> epc_in
  - br_taken -> br_target
  - jump_req -> jump_target
  - none -> pc_out + 4
  - redir = any of the four requests.
  - Arithmetic is 32-bit modulo: 32'hFFFFFFFC + 4 = 32'h00000000.
- State machine: two states, RUN and PEND.
  - RUN, ena=1: pc_out <= selected next PC.
  - RUN, ena=0, redir=0: pc_out holds.
  - RUN, ena=0, redir=1: pend_pc <= selected target; pend_pri <= its priority; state -> PEND; pc_out holds.
  - PEND, ena=1: pc_out <= pend_pc; state -> RUN.
    - A new redirect in this same cycle wins only if its priority is strictly higher than pend_pri; it then loads pc_out directly.
  - PEND, ena=0: a strictly-higher-priority redirect overwrites pend_pc/pend_pri. Equal or lower priority requests are dropped. State stays PEND.
  - redirect_pending = (state == PEND).
- Squash (combinational):
  - if_instr_out = 32'h00000000 when redir=1 or state==PEND; otherwise imem_rdata.
  - Effect: the fetch slot in the redirect cycle enters IF/ID as NOP. There are no delay slots.
- Latency:
  - Redirect with ena=1 -> target appears on imem_addr the next cycle.
  - Redirect during stall -> target appears the cycle after the first ena=1 edge.
- Requests are single-cycle pulses; the upstream logic does not repeat them. This block is the only place a stalled redirect is remembered.

Test Plan:
- Reset release, ena=1 constant, no requests, 4 cycles -> imem_addr sequence 0, 4, 8, 12. if_instr_out tracks imem_rdata. redirect_pending=0.
- At pc=0x10, br_taken=1, br_target=0x40, ena=1 -> if_instr_out=0 in that cycle. Next cycle imem_addr=0x40, then 0x44.
- ena=0; pulse jump_req (target 0x80) for 1 cycle; hold ena=0 for 3 cycles -> pc holds, redirect_pending=1, if_instr_out=0 throughout. Raise ena -> next cycle imem_addr=0x80, redirect_pending=0.
- Simultaneous exc_req, br_taken (0x40), jump_req with ena=1 -> next imem_addr=0x04 (EXC_VECTOR).
- PEND holding branch 0x40; during the stall pulse exc_req, then pulse jump_req -> exception overwrites, jump dropped. After ena=1, imem_addr=0x04.
- pc_out=0xFFFFFFFC, ena=1, no request -> next imem_addr=0x00000000. eret_req with epc_in=0x102 -> imem_addr=0x102, pc_addr_err=1.
- Assert reset low while in PEND -> immediately imem_addr=RESET_PC, redirect_pending=0. After release, sequential fetch from RESET_PC.
